sb_tx_packet_scheduler: RTL

SB_TX_PACKET_SCHEDULER -- requirements
Module: sb_tx_packet_scheduler

---
 rtl/sb_tx_packet_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sb_tx_packet_scheduler.sv
// Sideband TX packet scheduler: round-robin arbitration between two requesters, then
// 64-cycle word windows (LOAD + 63 SHIFT) per packet word followed by a GAP_UI idle gap.
module sb_tx_packet_scheduler #(
  parameter int unsigned GAP_UI = 32
) (
  input  logic        i_pll_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  input  logic        i_req1_valid,
  input  logic [63:0] i_req0_hdr,
  input  logic [63:0] i_req1_hdr,
  input  logic [63:0] i_req0_data,
  input  logic [63:0] i_req1_data,
  input  logic        i_req0_has_data,
  input  logic        i_req1_has_data,
  output logic        o_req0_ack,
  output logic        o_req1_ack,
  output logic [63:0] o_ser_data,
  output logic        o_ser_enable,
  output logic        o_ser_pack_finished,
  output logic        o_ser_last_pack,
  output logic        o_busy
);

  localparam logic [7:0] GapLast = 8'(GAP_UI);
  localparam logic [5:0] ShiftLast = 6'd63;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        second_word_q, second_word_d;
  logic [63:0] hdr_q, hdr_d;
  logic [63:0] data_q, data_d;
  logic        has_data_q, has_data_d;
  logic        prio_q, prio_d;
  logic        winner;

  logic        ack0_d, ack1_d;
  logic [63:0] ser_data_d;
  logic        ser_enable_d, pack_finished_d, last_pack_d, busy_d;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    second_word_d = second_word_q;
    hdr_d         = hdr_q;
    data_d        = data_q;
    has_data_d    = has_data_q;
    prio_d        = prio_q;
    winner        = 1'b0;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_req0_valid || i_req1_valid) begin
          // Pointer only decides a tie; a lone requester always wins.
          winner        = (i_req0_valid && i_req1_valid) ? prio_q : i_req1_valid;
          prio_d        = ~winner;
          state_d       = StLoad;
          second_word_d = 1'b0;
          bit_cnt_d     = 6'd0;
          gap_cnt_d     = 8'd0;
          if (winner) begin
            hdr_d      = i_req1_hdr;
            data_d     = i_req1_data;
            has_data_d = i_req1_has_data;
            ack1_d     = 1'b1;
          end else begin
            hdr_d      = i_req0_hdr;
            data_d     = i_req0_data;
            has_data_d = i_req0_has_data;
            ack0_d     = 1'b1;
          end
        end
      end
      StLoad: begin
        state_d   = StShift;
        bit_cnt_d = 6'd1;
      end
      StShift: begin
        if (bit_cnt_q == ShiftLast) begin
          bit_cnt_d = 6'd0;
          if (!second_word_q && has_data_q) begin
            state_d       = StLoad;
            second_word_d = 1'b1;
          end else begin
            state_d   = StGap;
            gap_cnt_d = 8'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d   = StIdle;
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from next-state so they register alongside the state change.
  always_comb begin
    ser_enable_d    = (state_d == StLoad) || (state_d == StShift);
    ser_data_d      = 64'd0;
    if (state_d == StLoad) begin
      ser_data_d = second_word_d ? data_d : hdr_d;
    end else if (state_d == StShift) begin
      ser_data_d = o_ser_data;
    end
    pack_finished_d = (state_d == StShift) && (bit_cnt_d == ShiftLast);
    last_pack_d     = ser_enable_d && (second_word_d || !has_data_d);
    busy_d          = (state_d != StIdle);
  end

  always_ff @(posedge i_pll_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q             <= StIdle;
      bit_cnt_q           <= 6'd0;
      gap_cnt_q           <= 8'd0;
      second_word_q       <= 1'b0;
      hdr_q               <= 64'd0;
      data_q              <= 64'd0;
      has_data_q          <= 1'b0;
      prio_q              <= 1'b0;
      o_req0_ack          <= 1'b0;
      o_req1_ack          <= 1'b0;
      o_ser_data          <= 64'd0;
      o_ser_enable        <= 1'b0;
      o_ser_pack_finished <= 1'b0;
      o_ser_last_pack     <= 1'b0;
      o_busy              <= 1'b0;
    end else begin
      state_q             <= state_d;
      bit_cnt_q           <= bit_cnt_d;
      gap_cnt_q           <= gap_cnt_d;
      second_word_q       <= second_word_d;
      hdr_q               <= hdr_d;
      data_q              <= data_d;
      has_data_q          <= has_data_d;
      prio_q              <= prio_d;
      o_req0_ack          <= ack0_d;
      o_req1_ack          <= ack1_d;
      o_ser_data          <= ser_data_d;
      o_ser_enable        <= ser_enable_d;
      o_ser_pack_finished <= pack_finished_d;
      o_ser_last_pack     <= last_pack_d;
      o_busy              <= busy_d;
    end
  end

endmodule
